// File: rtl/decoder_3_8.sv
`default_nettype none
// ============================================================================
// Module   : decoder_3_8
// Brief    : Registered 3-to-8 one-hot decoder with active-high enable and
//            optional output inversion (OUT_ACTIVE_LOW). Define the macro
//            DECODER_3_8_HIT_CNT_EN to add per-line saturating hit counters
//            readable through cnt_idx/cnt_val.
// Revision : 1.0 - initial release
// ============================================================================
module decoder_3_8 #(
    parameter bit OUT_ACTIVE_LOW = 1'b0
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [2:0] sel_in,
    input  logic       enable,
`ifdef DECODER_3_8_HIT_CNT_EN
    input  logic [2:0] cnt_idx,
    output logic [7:0] cnt_val,
`endif
    output logic [7:0] dec_out,
    output logic       dec_valid
);

    // XOR mask doubles as the idle/reset value of the output bus.
    localparam logic [7:0] c_pol_mask = OUT_ACTIVE_LOW ? 8'hFF : 8'h00;
    localparam logic [7:0] c_one      = 8'h01;
    localparam logic [7:0] c_cnt_max  = 8'hFF;

    logic [7:0] dec_raw;
    logic [7:0] dec_out_d;
    logic [7:0] dec_out_q;
    logic       dec_valid_d;
    logic       dec_valid_q;

    always_comb begin
        dec_raw     = 8'h00;
        if (enable) begin
            dec_raw = c_one << sel_in;
        end
        dec_out_d   = dec_raw ^ c_pol_mask;
        dec_valid_d = enable;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dec_out_q   <= c_pol_mask;
            dec_valid_q <= 1'b0;
        end else begin
            dec_out_q   <= dec_out_d;
            dec_valid_q <= dec_valid_d;
        end
    end

    assign dec_out   = dec_out_q;
    assign dec_valid = dec_valid_q;

`ifdef DECODER_3_8_HIT_CNT_EN
    logic [7:0] hit_cnt_d [8];
    logic [7:0] hit_cnt_q [8];
    logic [7:0] cnt_val_d;
    logic [7:0] cnt_val_q;

    always_comb begin
        for (int k = 0; k < 8; k++) begin
            hit_cnt_d[k] = hit_cnt_q[k];
            if (enable && (sel_in == 3'(k)) && (hit_cnt_q[k] != c_cnt_max)) begin
                hit_cnt_d[k] = hit_cnt_q[k] + 8'd1;
            end
        end
        // Read the current (pre-increment) value so a same-cycle hit is not visible yet.
        cnt_val_d = hit_cnt_q[cnt_idx];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int k = 0; k < 8; k++) begin
                hit_cnt_q[k] <= 8'h00;
            end
            cnt_val_q <= 8'h00;
        end else begin
            for (int k = 0; k < 8; k++) begin
                hit_cnt_q[k] <= hit_cnt_d[k];
            end
            cnt_val_q <= cnt_val_d;
        end
    end

    assign cnt_val = cnt_val_q;
`endif

`ifndef SYNTHESIS
    a_sel_known : assert property (@(posedge clk) disable iff (!rst_n)
        enable |-> !$isunknown(sel_in))
        else $error("decoder_3_8: sel_in unknown while enable is high");

    a_one_hot : assert property (@(posedge clk) disable iff (!rst_n)
        $onehot0(dec_out_q ^ c_pol_mask))
        else $error("decoder_3_8: more than one output line active");
`endif

endmodule
`default_nettype wire

// File: tb/tb_decoder_3_8.sv
`default_nettype none
// ============================================================================
// Module   : tb_decoder_3_8
// Brief    : Scoreboard bench for decoder_3_8; drives an active-high and an
//            active-low instance with identical directed vectors.
// Revision : 1.0 - initial release
// ============================================================================
module tb_decoder_3_8;

    typedef struct packed {
        logic [7:0] out;
        logic       valid;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [2:0] sel_in;
    logic       enable;
    logic [7:0] dec_out_hi;
    logic       dec_valid_hi;
    logic [7:0] dec_out_lo;
    logic       dec_valid_lo;
`ifdef DECODER_3_8_HIT_CNT_EN
    logic [2:0] cnt_idx;
    logic [7:0] cnt_val_hi;
    logic [7:0] cnt_val_lo;
`endif

    exp_t exp_q[$];
    int   n_checks = 0;
    int   n_fails  = 0;

    always #5 clk = ~clk;

    decoder_3_8 #(.OUT_ACTIVE_LOW(1'b0)) u_dut_hi (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel_in   (sel_in),
        .enable   (enable),
`ifdef DECODER_3_8_HIT_CNT_EN
        .cnt_idx  (cnt_idx),
        .cnt_val  (cnt_val_hi),
`endif
        .dec_out  (dec_out_hi),
        .dec_valid(dec_valid_hi)
    );

    decoder_3_8 #(.OUT_ACTIVE_LOW(1'b1)) u_dut_lo (
        .clk      (clk),
        .rst_n    (rst_n),
        .sel_in   (sel_in),
        .enable   (enable),
`ifdef DECODER_3_8_HIT_CNT_EN
        .cnt_idx  (cnt_idx),
        .cnt_val  (cnt_val_lo),
`endif
        .dec_out  (dec_out_lo),
        .dec_valid(dec_valid_lo)
    );

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
        n_checks++;
        if (act !== req) begin
            n_fails++;
            $display("FAIL %s: got %h, expected %h at %0t", name, act, req, $time);
        end
    endtask

    // Present one vector; the expected active-high response is queued.
    task automatic issue(input logic [2:0] s, input logic e, input logic [7:0] exp_out);
        @(negedge clk);
        sel_in = s;
        enable = e;
        exp_q.push_back('{out: exp_out, valid: e});
    endtask

    // Monitor: every registered output cycle with a pending expectation is scored.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            check("onehot_hi", 8'($countones(dec_out_hi) <= 1), 8'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                check("dec_out_hi",   dec_out_hi,         e.out);
                check("dec_valid_hi", {7'd0, dec_valid_hi}, {7'd0, e.valid});
                check("dec_out_lo",   dec_out_lo,         ~e.out);
                check("dec_valid_lo", {7'd0, dec_valid_lo}, {7'd0, e.valid});
            end
        end
    end

    logic [7:0] sweep [8] = '{8'h01, 8'h02, 8'h04, 8'h08, 8'h10, 8'h20, 8'h40, 8'h80};

    initial begin
        rst_n  = 1'b0;
        sel_in = 3'd3;
        enable = 1'b1;
`ifdef DECODER_3_8_HIT_CNT_EN
        cnt_idx = 3'd6;
`endif
        // Reset held with an active input pattern and clock running.
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_hi",   dec_out_hi,           8'h00);
        check("rst_valid_hi", {7'd0, dec_valid_hi}, 8'h00);
        check("rst_out_lo",   dec_out_lo,           8'hFF);
        check("rst_valid_lo", {7'd0, dec_valid_lo}, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;

        // Full sweep.
        for (int i = 0; i < 8; i++) issue(3'(i), 1'b1, sweep[i]);

        // Disable then re-enable on sel 5.
        issue(3'd5, 1'b0, 8'h00);
        issue(3'd5, 1'b1, 8'h20);

        // Polarity spot checks (active-low instance: FB then FF).
        issue(3'd2, 1'b1, 8'h04);
        issue(3'd2, 1'b0, 8'h00);

        // Toggle pattern: sel counts, enable high for 8 clocks then low for 8.
        for (int i = 0; i < 16; i++) issue(3'(i), (i < 8), (i < 8) ? sweep[i % 8] : 8'h00);

        // Asynchronous reset mid-cycle.
        issue(3'd4, 1'b1, 8'h10);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_out_hi",   dec_out_hi,           8'h00);
        check("async_valid_hi", {7'd0, dec_valid_hi}, 8'h00);
        check("async_out_lo",   dec_out_lo,           8'hFF);
        @(negedge clk);
        rst_n = 1'b1;
        issue(3'd7, 1'b1, 8'h80);
        issue(3'd0, 1'b1, 8'h01);

`ifdef DECODER_3_8_HIT_CNT_EN
        // Clear counters, then saturate counter 6.
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        check("cnt_rst", cnt_val_hi, 8'h00);
        rst_n   = 1'b1;
        cnt_idx = 3'd6;
        for (int i = 0; i < 300; i++) issue(3'd6, 1'b1, 8'h40);
        issue(3'd6, 1'b0, 8'h00);
        issue(3'd6, 1'b0, 8'h00);
        check("cnt6_sat", cnt_val_hi, 8'hFF);
        cnt_idx = 3'd0;
        issue(3'd6, 1'b0, 8'h00);
        issue(3'd6, 1'b0, 8'h00);
        check("cnt0_zero", cnt_val_hi, 8'h00);
        @(negedge clk);
        rst_n = 1'b0;
        cnt_idx = 3'd6;
        #1;
        check("cnt_rst_again", cnt_val_lo, 8'h00);
        @(negedge clk);
        rst_n = 1'b1;
`endif

        // Drain the scoreboard with a bounded wait.
        for (int i = 0; i < 10 && exp_q.size() != 0; i++) @(posedge clk);
        #2;
        if (exp_q.size() != 0) begin
            n_checks++;
            n_fails++;
            $display("FAIL drain: %0d entries left, expected 0", exp_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
`default_nettype wire
